// File: rtl/rx_pkt_parser.sv
// rx_pkt_parser: receive-side packet parser feeding the node-info block.
// Consumes a word stream, decodes the packet type in word0, captures the
// fields that type carries into shadow registers, and on a well-formed packet
// publishes them as registered outputs together with a one-cycle en_MNI strobe.
// Malformed or unknown-type packets are consumed, discarded and counted.
module rx_pkt_parser #(
    parameter int WORD_WIDTH = 16,
    parameter int DROP_CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    input  logic                  data_last,
    output logic                  data_ready,
    output logic                  en_MNI,
    output logic [2:0]            fPktType,
    output logic [WORD_WIDTH-1:0] hops,
    output logic [WORD_WIDTH-1:0] e_max,
    output logic [WORD_WIDTH-1:0] e_min,
    output logic [WORD_WIDTH-1:0] e_threshold,
    output logic [WORD_WIDTH-1:0] destinationID,
    output logic [WORD_WIDTH-1:0] timeslot,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    // ------------------------------------------------------------------
    // Packet types carried in word0[15:13]
    // ------------------------------------------------------------------
    localparam logic [2:0] T_HB   = 3'b000;
    localparam logic [2:0] T_CHE  = 3'b001;
    localparam logic [2:0] T_INV  = 3'b010;
    localparam logic [2:0] T_CHTS = 3'b100;
    localparam logic [2:0] T_DATA = 3'b101;
    localparam logic [2:0] T_NONE = 3'b111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FIELDS,
        S_DROP,
        S_COMMIT
    } state_e;

    // Index of the final word of a packet of the given type (word0 = index 0).
    function automatic logic [2:0] last_idx(input logic [2:0] t);
        case (t)
            T_HB:          last_idx = 3'd5;
            T_CHE, T_INV:  last_idx = 3'd2;
            T_CHTS, T_DATA: last_idx = 3'd4;
            default:       last_idx = 3'd0;
        endcase
    endfunction

    function automatic logic type_ok(input logic [2:0] t);
        case (t)
            T_HB, T_CHE, T_INV, T_CHTS, T_DATA: type_ok = 1'b1;
            default:                            type_ok = 1'b0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                state_q,   state_d;
    logic [2:0]            ptype_q,   ptype_d;   // type of the packet in flight
    logic [2:0]            cnt_q,     cnt_d;     // index of the next word expected
    logic                  good_q,    good_d;    // DROP is swallowing extras of a complete packet

    // Shadow copies, filled while the packet streams in
    logic [WORD_WIDTH-1:0] sh_hops_q, sh_hops_d;
    logic [WORD_WIDTH-1:0] sh_emax_q, sh_emax_d;
    logic [WORD_WIDTH-1:0] sh_emin_q, sh_emin_d;
    logic [WORD_WIDTH-1:0] sh_thr_q,  sh_thr_d;
    logic [WORD_WIDTH-1:0] sh_dest_q, sh_dest_d;
    logic [WORD_WIDTH-1:0] sh_ts_q,   sh_ts_d;

    // Published outputs
    logic                  ready_q,   ready_d;
    logic                  en_q,      en_d;
    logic [2:0]            ftype_q,   ftype_d;
    logic [WORD_WIDTH-1:0] hops_q,    hops_d;
    logic [WORD_WIDTH-1:0] emax_q,    emax_d;
    logic [WORD_WIDTH-1:0] emin_q,    emin_d;
    logic [WORD_WIDTH-1:0] thr_q,     thr_d;
    logic [WORD_WIDTH-1:0] dest_q,    dest_d;
    logic [WORD_WIDTH-1:0] ts_q,      ts_d;
    logic [DROP_CNT_W-1:0] drop_q,    drop_d;

    logic                  accept;
    logic                  commit;
    logic                  drop_inc;
    logic [2:0]            word_type;

    assign accept    = data_valid && ready_q;
    assign word_type = data_in[WORD_WIDTH-1 -: 3];

    // Next-state, shadow capture and commit/drop decisions
    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // can leave one unassigned and infer a latch.
        state_d   = state_q;
        ptype_d   = ptype_q;
        cnt_d     = cnt_q;
        good_d    = good_q;
        sh_hops_d = sh_hops_q;
        sh_emax_d = sh_emax_q;
        sh_emin_d = sh_emin_q;
        sh_thr_d  = sh_thr_q;
        sh_dest_d = sh_dest_q;
        sh_ts_d   = sh_ts_q;
        ready_d   = 1'b1;
        en_d      = 1'b0;
        ftype_d   = ftype_q;
        hops_d    = hops_q;
        emax_d    = emax_q;
        emin_d    = emin_q;
        thr_d     = thr_q;
        dest_d    = dest_q;
        ts_d      = ts_q;
        drop_d    = drop_q;
        commit    = 1'b0;
        drop_inc  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    ptype_d = word_type;
                    good_d  = 1'b0;
                    if (data_last) begin
                        // A one-word packet is malformed whatever its type.
                        drop_inc = 1'b1;
                    end else if (type_ok(word_type)) begin
                        state_d = S_HDR;
                        cnt_d   = 3'd1;
                    end else begin
                        state_d = S_DROP;
                    end
                end
            end

            S_HDR: begin
                // sourceID is consumed and discarded.
                if (accept) begin
                    if (data_last) begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        state_d = S_FIELDS;
                        cnt_d   = 3'd2;
                    end
                end
            end

            S_FIELDS: begin
                if (accept) begin
                    case (ptype_q)
                        T_HB: begin
                            case (cnt_q)
                                3'd2:    sh_hops_d = data_in;
                                3'd3:    sh_emax_d = data_in;
                                3'd4:    sh_emin_d = data_in;
                                3'd5:    sh_thr_d  = data_in;
                                default: ;
                            endcase
                        end
                        T_CHE, T_INV: begin
                            if (cnt_q == 3'd2) sh_dest_d = data_in;
                        end
                        T_CHTS: begin
                            case (cnt_q)
                                3'd2:    sh_dest_d = data_in;
                                3'd3:    sh_hops_d = data_in;
                                3'd4:    sh_ts_d   = data_in;
                                default: ;
                            endcase
                        end
                        T_DATA: begin
                            // word4 is payload and is not captured.
                            case (cnt_q)
                                3'd2:    sh_dest_d = data_in;
                                3'd3:    sh_hops_d = data_in;
                                default: ;
                            endcase
                        end
                        default: ;
                    endcase

                    if (data_last) begin
                        if (cnt_q == last_idx(ptype_q)) begin
                            commit = 1'b1;
                        end else begin
                            drop_inc = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end else if (cnt_q == last_idx(ptype_q)) begin
                        // Complete packet with trailing words: swallow them,
                        // then commit on data_last.
                        state_d = S_DROP;
                        good_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end

            S_DROP: begin
                if (accept && data_last) begin
                    if (good_q) begin
                        commit = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end

            S_COMMIT: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Publish on the same edge that accepts the last word, so the strobe
        // and the fields are visible in the COMMIT cycle that follows.
        if (commit) begin
            state_d = S_COMMIT;
            ready_d = 1'b0;
            en_d    = 1'b1;
            ftype_d = ptype_q;
            case (ptype_q)
                T_HB: begin
                    hops_d = sh_hops_d;
                    emax_d = sh_emax_d;
                    emin_d = sh_emin_d;
                    thr_d  = sh_thr_d;
                end
                T_CHE, T_INV: begin
                    dest_d = sh_dest_d;
                end
                T_CHTS: begin
                    dest_d = sh_dest_d;
                    hops_d = sh_hops_d;
                    ts_d   = sh_ts_d;
                end
                T_DATA: begin
                    dest_d = sh_dest_d;
                    hops_d = sh_hops_d;
                end
                default: ;
            endcase
        end

        // Saturating drop counter.
        if (drop_inc && (drop_q != {DROP_CNT_W{1'b1}})) begin
            drop_d = drop_q + DROP_CNT_W'(1);
        end
    end

    // State and output registers; reset abandons any partial packet
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            ptype_q   <= T_NONE;
            cnt_q     <= '0;
            good_q    <= 1'b0;
            sh_hops_q <= '0;
            sh_emax_q <= '0;
            sh_emin_q <= '0;
            sh_thr_q  <= '0;
            sh_dest_q <= '0;
            sh_ts_q   <= '0;
            ready_q   <= 1'b1;
            en_q      <= 1'b0;
            ftype_q   <= T_NONE;
            hops_q    <= '0;
            emax_q    <= '0;
            emin_q    <= '0;
            thr_q     <= '0;
            dest_q    <= '0;
            ts_q      <= '0;
            drop_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge value of the others, independent of statement order.
            state_q   <= state_d;
            ptype_q   <= ptype_d;
            cnt_q     <= cnt_d;
            good_q    <= good_d;
            sh_hops_q <= sh_hops_d;
            sh_emax_q <= sh_emax_d;
            sh_emin_q <= sh_emin_d;
            sh_thr_q  <= sh_thr_d;
            sh_dest_q <= sh_dest_d;
            sh_ts_q   <= sh_ts_d;
            ready_q   <= ready_d;
            en_q      <= en_d;
            ftype_q   <= ftype_d;
            hops_q    <= hops_d;
            emax_q    <= emax_d;
            emin_q    <= emin_d;
            thr_q     <= thr_d;
            dest_q    <= dest_d;
            ts_q      <= ts_d;
            drop_q    <= drop_d;
        end
    end

    assign data_ready    = ready_q;
    assign en_MNI        = en_q;
    assign fPktType      = ftype_q;
    assign hops          = hops_q;
    assign e_max         = emax_q;
    assign e_min         = emin_q;
    assign e_threshold   = thr_q;
    assign destinationID = dest_q;
    assign timeslot      = ts_q;
    assign drop_cnt      = drop_q;

endmodule

// File: doc/rx_pkt_parser.md
Name: rx_pkt_parser

Overview:
- Sits directly upstream of the node-info block (myNodeInfo).
- Accepts a received packet as a stream of 16-bit words from the radio/receive buffer. Decodes the packet type, extracts the fields that packet carries, and presents them as stable registered outputs with a one-cycle en_MNI strobe.
- Malformed and unknown-type packets are dropped and counted; no strobe is issued for them.

Parameters:
- WORD_WIDTH, 16, width of the stream word and of every field output.
- DROP_CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- data_in  input  WORD_WIDTH  received packet word.
- data_valid  input  1  data_in is valid this cycle.
- data_last  input  1  current word is the last of the packet.
- data_ready  output  1  parser can accept a word; a word transfers when data_valid && data_ready.
- en_MNI  output  1  one-cycle strobe: the field outputs hold a newly committed packet.
- fPktType  output  3  type of the last committed packet.
- hops  output  WORD_WIDTH  hop count field.
- e_max  output  WORD_WIDTH  HB max energy (14.2 fixed point).
- e_min  output  WORD_WIDTH  HB min energy.
- e_threshold  output  WORD_WIDTH  HB energy threshold.
- destinationID  output  WORD_WIDTH  destination node ID field.
- timeslot  output  WORD_WIDTH  CHTimeslot slot number.
- drop_cnt  output  DROP_CNT_W  number of dropped packets, saturating.

Behaviour:
- Reset values: fPktType=3'b111, data_ready=1, en_MNI=0, drop_cnt=0, all field outputs 0. Reset is asynchronous and may occur mid-packet: the partial packet is discarded, the FSM goes to IDLE, and no strobe is issued.
- Packet format: word0 [15:13] = type, [12:0] ignored; word1 = sourceID, which is discarded. Remaining words by type:
  - HB 000: hops, e_max, e_min, e_threshold. 6 words total.
  - CHE 001: destinationID. 3 words.
  - INV 010: destinationID. 3 words.
  - CHTimeslot 100: destinationID, hops, timeslot. 5 words.
  - DATA 101: destinationID, hops, payload (ignored). 5 words.
  - 011, 110, 111: invalid.
- FSM states: IDLE, HDR, FIELDS, DROP, COMMIT.
  - IDLE: an accepted word is word0. Valid type -> HDR with word counter=1. Invalid type -> DROP. If word0 also has data_last -> malformed: drop_cnt++ and stay IDLE.
  - HDR: accept sourceID -> FIELDS. data_last here -> malformed: drop_cnt++, go IDLE.
  - FIELDS: each accepted word is written into the shadow register selected by type and word index. data_last on the expected final word -> COMMIT. data_last before the expected final word -> malformed: drop_cnt++, shadow discarded, go IDLE. Expected final word without data_last -> DROP_EXTRA; see next item.
  - Extra words beyond the expected count are ignored (DROP state, flag good=1). The packet commits when data_last arrives; it is not counted as a drop.
  - DROP: consume words until data_last. If good=0, drop_cnt++ on that last word. Then go IDLE, or go COMMIT if good=1.
  - COMMIT: lasts one cycle, with data_ready=0. Outputs for the fields the packet carries, plus fPktType, are loaded from shadow. Fields the packet does not carry retain their previous value. en_MNI=1 in this cycle only. Next state is IDLE.
- Latency: last word accepted at edge N -> outputs and en_MNI valid from edge N until edge N+1. Next word is accepted no earlier than edge N+2.
- data_ready=1 in every state except COMMIT.
- Field outputs change only in COMMIT and never mid-packet.
- drop_cnt saturates at all-ones; it does not wrap.
- data_valid=0 cycles may appear anywhere inside a packet; the state is held.
- data_last is ignored when data_valid=0.

Test Plan:
- HB stream 0x0000, 0x0007, 0x0001, 0x8000, 0x4000, 0x3333 (last) -> one cycle after the last accept: en_MNI=1 for exactly 1 cycle, fPktType=000, hops=1, e_max=0x8000, e_min=0x4000, e_threshold=0x3333; data_ready=0 in that cycle.
- CHE 0x2000, 0x0005, 0x000C (last) after the HB -> fPktType=001, destinationID=0x000C; hops and e_max remain 1 and 0x8000.
- CHTimeslot 0x8000, 0x0003, 0x0015, 0x0002, 0x0004 (last) with a data_valid gap of 3 cycles inside the packet -> destinationID=0x15, hops=2, timeslot=4, with a single strobe.
- Truncated HB 0x0000, 0x0001, 0x0002 (last) -> no en_MNI, outputs unchanged, drop_cnt increments by 1. Type 0x6000 followed by 2 words -> drop_cnt increments by 1 again.
- Oversized CHE with 5 words -> commits on the 5th word with destinationID from word2; drop_cnt unchanged. Then 300 invalid single-word packets -> drop_cnt=255.
- nrst pulse after word 3 of an HB -> all outputs at reset values. A following CHE packet commits normally.
